uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_baud_gen.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the arbitrated UART transmitter:
//   - state_t        : transmitter FSM states (PARITY exists only when
//                      UART_TX_PARITY_EN is defined)
//   - DATA_BITS      : payload bits per frame
//   - FRAME_BITS     : total bits per frame (start + data [+ parity] + stop)
//   - calc_div()     : clock cycles per serial bit from MHz clock and baud rate
// Optional feature macro: UART_TX_PARITY_EN (even parity bit before stop).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    // Integer division truncates, matching the nominal bit period in cycles.
    function automatic int calc_div(input int clock_mhz, input int baud);
        return (clock_mhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter. Counts 0..DIV-1 and raises tick for one cycle at DIV-1.
// Ports:
//   clk     in  : clock, rising edge
//   rst     in  : synchronous active-high reset (count -> 0)
//   restart in  : force the count back to 0 on the next edge (state entry)
//   tick    out : high while count == DIV-1
// -----------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int DIV = 434
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (rst || restart || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Two-requester round-robin arbiter feeding a single UART transmitter (8N1, or
// 8E1 when UART_TX_PARITY_EN is defined).
// Parameters:
//   CLOCK     : system clock in MHz
//   BAUD      : serial bit rate in bit/s
// Ports:
//   clk       in  : clock, rising edge
//   rst       in  : synchronous active-high reset
//   req_valid in  : [1:0] per-requester byte valid
//   req0_data in  : requester 0 byte
//   req1_data in  : requester 1 byte
//   req_ready out : [1:0] accept strobe, only to the arbitration winner in IDLE
//   tx        out : registered serial line, idle high
//   busy      out : high while a frame is in progress
//   grant_id  out : requester of the current or last accepted byte
// Optional feature macro: UART_TX_PARITY_EN.
// -----------------------------------------------------------------------------
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int CLOCK = 50,
    parameter int BAUD  = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic [1:0] req_ready,
    output logic       tx,
    output logic       busy,
    output logic       grant_id
);

    localparam int DIV = calc_div(CLOCK, BAUD);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_tx_arbiter: CLOCK/BAUD give DIV < 2");
        end
    endgenerate

    state_t     state, state_n;
    logic       tx_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [7:0] data_q;
    logic       ptr;
    logic       win;
    logic       accept;
    logic       restart;
    logic       tick;

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // With both requesting, the pointer decides; otherwise the lone requester wins.
    assign win  = (req_valid == 2'b11) ? ptr : req_valid[1];
    assign busy = (state != IDLE);

    always_comb begin
        state_n   = state;
        tx_n      = tx;
        bit_idx_n = bit_idx;
        restart   = 1'b0;
        accept    = 1'b0;
        req_ready = 2'b00;
        case (state)
            IDLE: begin
                tx_n = 1'b1;
                // Ready is suppressed during reset so nothing is accepted then.
                if (!rst && (req_valid != 2'b00)) begin
                    accept         = 1'b1;
                    req_ready[win] = 1'b1;
                    state_n        = START;
                    tx_n           = 1'b0;
                    restart        = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_n   = DATA;
                    tx_n      = data_q[0];
                    bit_idx_n = 3'd0;
                    restart   = 1'b1;
                end
            end
            DATA: begin
                if (tick) begin
                    restart = 1'b1;
                    // Leave on the last bit rather than letting the index wrap.
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = ^data_q;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        tx_n      = data_q[bit_idx + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    restart = 1'b1;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    restart = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            bit_idx  <= 3'd0;
            grant_id <= 1'b0;
            ptr      <= 1'b0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            bit_idx <= bit_idx_n;
            if (accept) begin
                grant_id <= win;
                ptr      <= ~win;
            end
        end
    end

    // Payload holding register; requesters may change data after acceptance.
    always_ff @(posedge clk) begin
        if (accept) begin
            data_q <= win ? req1_data : req0_data;
        end
    end

endmodule
